key_step_debounce: RTL and testbench

//  Upstream conditioning stage for the HEX0 state-sequencer FSM. Takes the raw

---
 rtl/key_step_debounce.sv | 149 ++++++++++++++
 tb/tb_key_step_debounce.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/key_step_debounce.sv
// Push-button conditioner: synchronises and debounces a raw active-low key and
// a direction switch, then emits one-cycle step pulses with optional auto-repeat.
module key_step_debounce #(
  parameter int CW         = 20,
  parameter int DB_CYCLES  = 50000,
  parameter int REPEAT_DLY = 0,
  parameter int REPEAT_PER = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  input  logic sw_dir,
  output logic step,
  output logic step_up,
  output logic key_held
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_e;

  localparam bit          RPT_EN      = (REPEAT_DLY != 0);
  localparam logic [CW-1:0] DB_LAST     = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] RP_DLY_LAST = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0] RP_PER_LAST = CW'(REPEAT_PER - 1);

  logic [1:0]    key_sync_q;
  logic [1:0]    dir_sync_q;
  logic          key_s;
  logic          dir_s;

  state_e        state_q, state_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic [CW-1:0] rp_cnt_q, rp_cnt_d;
  logic          rp_arm_q, rp_arm_d;
  logic          step_q, step_d;
  logic          step_up_q, step_up_d;
  logic          held_q, held_d;

  // Both synchroniser chains idle high: key released, direction up.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_sync_q <= 2'b11;
      dir_sync_q <= 2'b11;
    end else begin
      key_sync_q <= {key_sync_q[0], key_n};
      dir_sync_q <= {dir_sync_q[0], sw_dir};
    end
  end

  assign key_s = key_sync_q[1];
  assign dir_s = dir_sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      db_cnt_q  <= '0;
      rp_cnt_q  <= '0;
      rp_arm_q  <= 1'b0;
      step_q    <= 1'b0;
      step_up_q <= 1'b1;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      db_cnt_q  <= db_cnt_d;
      rp_cnt_q  <= rp_cnt_d;
      rp_arm_q  <= rp_arm_d;
      step_q    <= step_d;
      step_up_q <= step_up_d;
      held_q    <= held_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path through the
  // block leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    rp_cnt_d  = rp_cnt_q;
    rp_arm_d  = rp_arm_q;
    step_d    = 1'b0;
    step_up_d = step_up_q;
    held_d    = held_q;

    unique case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d  = PRESS_CHK;
          db_cnt_d = '0;
        end
      end
      PRESS_CHK: begin
        if (key_s) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = HELD;
          step_d    = 1'b1;
          step_up_d = dir_s;
          held_d    = 1'b1;
          rp_cnt_d  = '0;
          rp_arm_d  = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (key_s) begin
          state_d  = REL_CHK;
          db_cnt_d = '0;
          rp_cnt_d = '0;
          rp_arm_d = 1'b0;
        end else if (RPT_EN) begin
          // First repeat waits REPEAT_DLY cycles, later ones REPEAT_PER.
          if (rp_cnt_q == (rp_arm_q ? RP_PER_LAST : RP_DLY_LAST)) begin
            step_d    = 1'b1;
            step_up_d = dir_s;
            rp_cnt_d  = '0;
            rp_arm_d  = 1'b1;
          end else begin
            rp_cnt_d = rp_cnt_q + CW'(1);
          end
        end
      end
      REL_CHK: begin
        if (!key_s) begin
          state_d  = HELD;
          rp_cnt_d = '0;
          rp_arm_d = 1'b0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = IDLE;
          held_d  = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign step     = step_q;
  assign step_up  = step_up_q;
  assign key_held = held_q;

endmodule

// File: tb/tb_key_step_debounce.sv
// Directed bench: one debouncer without repeat, one with REPEAT_DLY=10/PER=5,
// both with DB_CYCLES=4. Inputs change on the falling edge, outputs sampled there.
module tb_key_step_debounce;

  logic clk;
  logic reset, key_n, sw_dir;
  logic step, step_up, key_held;
  logic reset2, key_n2, sw_dir2;
  logic step2, step_up2, key_held2;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_step   = 0;
  int n_step2  = 0;

  key_step_debounce #(.CW(8), .DB_CYCLES(4), .REPEAT_DLY(0), .REPEAT_PER(0)) u_dut (
    .clk(clk), .reset(reset), .key_n(key_n), .sw_dir(sw_dir),
    .step(step), .step_up(step_up), .key_held(key_held)
  );

  key_step_debounce #(.CW(8), .DB_CYCLES(4), .REPEAT_DLY(10), .REPEAT_PER(5)) u_rpt (
    .clk(clk), .reset(reset2), .key_n(key_n2), .sw_dir(sw_dir2),
    .step(step2), .step_up(step_up2), .key_held(key_held2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step pulses counted shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (step === 1'b1)  n_step++;
    if (step2 === 1'b1) n_step2++;
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; key_n = 1'b1; sw_dir = 1'b1;
    reset2 = 1'b1; key_n2 = 1'b1; sw_dir2 = 1'b1;
    @(negedge clk);

    // 1: reset held while the key chatters every cycle
    for (int i = 0; i < 8; i++) begin
      key_n = i[0];
      cyc();
      check("rst_step", step, 0);
      check("rst_held", key_held, 0);
      check("rst_up", step_up, 1);
    end
    key_n = 1'b1;
    reset = 1'b0; reset2 = 1'b0;
    repeat (4) cyc();
    check("idle_no_step", n_step, 0);

    // 2: clean press, step exactly 7 edges after the first low sample
    key_n = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      check("press_wait_step", step, 0);
    end
    cyc();
    check("press_step", step, 1);
    check("press_held", key_held, 1);
    check("press_up", step_up, 1);
    repeat (29) cyc();
    check("hold_single_step", n_step, 1);
    check("hold_held", key_held, 1);
    key_n = 1'b1;
    repeat (6) cyc();
    check("rel_held_before", key_held, 1);
    cyc();
    check("rel_held_after", key_held, 0);
    check("rel_no_step", n_step, 1);

    // 3: short bounces rejected, long press accepted once
    key_n = 1'b0; repeat (3) cyc();
    key_n = 1'b1; cyc();
    key_n = 1'b0; repeat (3) cyc();
    key_n = 1'b1; repeat (4) cyc();
    check("bounce_rejected", n_step, 1);
    check("bounce_not_held", key_held, 0);
    key_n = 1'b0; repeat (20) cyc();
    check("bounce_then_press", n_step, 2);
    check("bounce_press_held", key_held, 1);
    key_n = 1'b1; repeat (10) cyc();
    check("bounce_released", key_held, 0);

    // 4: release glitch while held keeps the key held without a step
    key_n = 1'b0; repeat (10) cyc();
    check("glitch_press", n_step, 3);
    key_n = 1'b1; repeat (2) cyc();
    key_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("glitch_held", key_held, 1);
    end
    check("glitch_no_step", n_step, 3);
    key_n = 1'b1;
    repeat (6) cyc();
    check("glitch_rel_before", key_held, 1);
    cyc();
    check("glitch_rel_after", key_held, 0);
    repeat (3) cyc();
    check("glitch_rel_no_step", n_step, 3);

    // 5: direction captured only at the step
    sw_dir = 1'b0; repeat (3) cyc();
    key_n = 1'b0; repeat (7) cyc();
    check("dir_down_step", step, 1);
    check("dir_down_up", step_up, 0);
    sw_dir = 1'b1; repeat (5) cyc();
    check("dir_held_up", step_up, 0);
    key_n = 1'b1; repeat (10) cyc();
    check("dir_idle_up", step_up, 0);
    check("dir_idle_held", key_held, 0);
    key_n = 1'b0; repeat (7) cyc();
    check("dir_up_step", step, 1);
    check("dir_up_up", step_up, 1);
    check("dir_steps", n_step, 5);
    key_n = 1'b1; repeat (10) cyc();

    // 6: auto-repeat at +10, +15, +20, +25, +30 after the first step
    key_n2 = 1'b0; repeat (7) cyc();
    check("rpt_first_step", step2, 1);
    check("rpt_first_up", step_up2, 1);
    for (int k = 1; k <= 32; k++) begin
      if (k == 12) sw_dir2 = 1'b0;
      cyc();
      check($sformatf("rpt_step_k%0d", k), step2, (k >= 10 && k % 5 == 0) ? 1 : 0);
    end
    check("rpt_total", n_step2, 6);
    check("rpt_dir_followed", step_up2, 0);
    key_n2 = 1'b1; repeat (10) cyc();
    check("rpt_released", key_held2, 0);
    check("rpt_rel_no_step", n_step2, 6);

    // 6b: reset in the middle of the press debounce
    key_n2 = 1'b0; repeat (4) cyc();
    reset2 = 1'b1;
    #1;
    check("midrst_step", step2, 0);
    check("midrst_held", key_held2, 0);
    check("midrst_up", step_up2, 1);
    repeat (2) cyc();
    check("midrst_no_step", n_step2, 6);
    reset2 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      check("postrst_wait", step2, 0);
    end
    cyc();
    check("postrst_step", step2, 1);
    check("postrst_up", step_up2, 0);
    check("postrst_held", key_held2, 1);
    check("postrst_total", n_step2, 7);
    key_n2 = 1'b1; repeat (10) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
